cpu_sequencer: RTL and testbench

Multi-cycle sequencer for the 16-bit tiny core. It owns the PC, instruction register and memory-data register. It walks each instruction through fetch/decode/execute/memory/writeback and shares the single-port memory between instruction fetch and load/store. The combinational control unit decodes `ir`, and this block gates that unit's write strobes so each architectural write happens exactly once per instruction.

---
 rtl/cpu_sequencer_pkg.sv | 19 +
 rtl/cpu_sequencer.sv | 164 ++++++++++++++++
 tb/tb_cpu_sequencer.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/cpu_sequencer_pkg.sv
// cpu_sequencer_pkg: shared encodings for the tiny-core multi-cycle sequencer.
//   seq_state_e - FSM state encoding (also exported on the debug `state` port)
//   INSTR_HALT  - instruction word that stops the core
package cpu_sequencer_pkg;

  typedef enum logic [2:0] {
    SEQ_IDLE   = 3'd0,
    SEQ_FETCH  = 3'd1,
    SEQ_DECODE = 3'd2,
    SEQ_EXEC   = 3'd3,
    SEQ_MEM    = 3'd4,
    SEQ_WB     = 3'd5,
    SEQ_HALT   = 3'd6,
    SEQ_PAUSE  = 3'd7
  } seq_state_e;

  localparam logic [15:0] INSTR_HALT = 16'hFFFF;

endpackage

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle sequencer for the 16-bit tiny core.
// Owns PC/IR/MDR, walks each instruction through
// FETCH -> DECODE -> EXEC -> [MEM] -> [WB], shares the single-port memory
// between instruction fetch and load/store, and gates the control unit's
// write strobes to one pulse per instruction.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   run                   execution enable, sampled at instruction boundaries
//   mem_req/we/addr/wdata memory request (held stable until mem_ready)
//   mem_rdata, mem_ready  memory response
//   ir, pc, mdr           architectural registers
//   cu_*                  decoded control from the external control unit
//   alu_result            ALU output / load-store effective address
//   store_data            register-file port-2 data (store data)
//   branch_taken/target   from the external branch unit
//   rf_we, flag_we        single-cycle write pulses in WB
//   halted, state         status / debug
//
// Config macro CPU_SEQ_STEP_EN: adds input `step`; every instruction
// boundary parks in PAUSE until a step pulse.
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int                  PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC = 16'h0000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
`ifdef CPU_SEQ_STEP_EN
  input  logic                step,
`endif
  output logic                mem_req,
  output logic                mem_we,
  output logic [PC_WIDTH-1:0] mem_addr,
  output logic [15:0]         mem_wdata,
  input  logic [15:0]         mem_rdata,
  input  logic                mem_ready,
  output logic [15:0]         ir,
  output logic [PC_WIDTH-1:0] pc,
  output logic [15:0]         mdr,
  input  logic                cu_reg_write,
  input  logic                cu_mem_read,
  input  logic                cu_mem_write,
  input  logic                cu_flag_write,
  input  logic                cu_is_branch,
  input  logic [15:0]         alu_result,
  input  logic [15:0]         store_data,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  output logic                rf_we,
  output logic                flag_we,
  output logic                halted,
  output logic [2:0]          state
);

  seq_state_e          state_q, state_d, bnd_state;
  logic [PC_WIDTH-1:0] pc_q, pc_d, mem_addr_q, mem_addr_d;
  logic [15:0]         ir_q, ir_d, mdr_q, mdr_d;
  logic                mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic                rf_we_q, rf_we_d, flag_we_q, flag_we_d;
  logic                halted_q, halted_d;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    mdr_d   = mdr_q;

    // Where an instruction goes once it has retired.
`ifdef CPU_SEQ_STEP_EN
    bnd_state = SEQ_PAUSE;
`else
    bnd_state = run ? SEQ_FETCH : SEQ_IDLE;
`endif

    case (state_q)
      SEQ_IDLE:   if (run) state_d = SEQ_FETCH;
      SEQ_FETCH:  if (mem_ready) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + {{(PC_WIDTH-1){1'b0}}, 1'b1};
                    state_d = SEQ_DECODE;
                  end
      SEQ_DECODE: state_d = (ir_q == INSTR_HALT) ? SEQ_HALT : SEQ_EXEC;
      SEQ_EXEC:   if (cu_is_branch) begin
                    if (branch_taken) pc_d = branch_target;
                    state_d = bnd_state;
                  end else if (cu_mem_read || cu_mem_write) begin
                    state_d = SEQ_MEM;
                  end else begin
                    state_d = SEQ_WB;
                  end
      SEQ_MEM:    if (mem_ready) begin
                    if (cu_mem_write) begin
                      state_d = bnd_state;
                    end else begin
                      mdr_d   = mem_rdata;
                      state_d = SEQ_WB;
                    end
                  end
      SEQ_WB:     state_d = bnd_state;
      SEQ_HALT:   state_d = SEQ_HALT;
`ifdef CPU_SEQ_STEP_EN
      SEQ_PAUSE:  if (step) state_d = run ? SEQ_FETCH : SEQ_IDLE;
`else
      SEQ_PAUSE:  state_d = SEQ_IDLE;
`endif
      default:    state_d = SEQ_IDLE;
    endcase

    // Outputs are registered: decode them from the state being entered so
    // they are valid in the first cycle of that state. IR is unchanged
    // through EXEC/MEM/WB, so the control unit's outputs (and alu_result)
    // are stable for the whole access, which keeps addr/we steady on waits.
    mem_req_d  = (state_d == SEQ_FETCH) || (state_d == SEQ_MEM);
    mem_we_d   = (state_d == SEQ_MEM) && cu_mem_write;
    mem_addr_d = '0;
    if (state_d == SEQ_FETCH)    mem_addr_d = pc_d;
    else if (state_d == SEQ_MEM) mem_addr_d = alu_result[PC_WIDTH-1:0];
    rf_we_d    = (state_d == SEQ_WB) && cu_reg_write;
    flag_we_d  = (state_d == SEQ_WB) && cu_flag_write;
    halted_d   = (state_d == SEQ_HALT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SEQ_IDLE;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      mdr_q      <= '0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      rf_we_q    <= 1'b0;
      flag_we_q  <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      mdr_q      <= mdr_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      rf_we_q    <= rf_we_d;
      flag_we_q  <= flag_we_d;
      halted_q   <= halted_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = store_data;
  assign ir        = ir_q;
  assign pc        = pc_q;
  assign mdr       = mdr_q;
  assign rf_we     = rf_we_q;
  assign flag_we   = flag_we_q;
  assign halted    = halted_q;
  assign state     = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: plays memory, control unit and branch unit.
// Program: ADDI, LD [0x12] (2 waits), ST [0x20], NOP, NOP, BR (taken first
// time to 3, then not taken), HALT.
module tb_cpu_sequencer;

  logic        clk = 1'b0, rst_n = 1'b0, run = 1'b0;
  logic        mem_req, mem_we, mem_ready;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, ir, pc, mdr;
  logic        cu_reg_write, cu_mem_read, cu_mem_write, cu_flag_write, cu_is_branch;
  logic [15:0] alu_result, store_data, branch_target;
  logic        branch_taken, rf_we, flag_we, halted;
  logic [2:0]  state;

  cpu_sequencer #(.PC_WIDTH(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .ir(ir), .pc(pc), .mdr(mdr),
    .cu_reg_write(cu_reg_write), .cu_mem_read(cu_mem_read), .cu_mem_write(cu_mem_write),
    .cu_flag_write(cu_flag_write), .cu_is_branch(cu_is_branch),
    .alu_result(alu_result), .store_data(store_data),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .rf_we(rf_we), .flag_we(flag_we), .halted(halted), .state(state)
  );

  always #5 clk = ~clk;

  // memory model with per-address wait states
  logic [15:0] mem [0:255];
  int          waits [0:255];
  int          wcnt, cyc;
  logic        br_seen = 1'b0;

  assign mem_ready = mem_req && (wcnt >= waits[mem_addr[7:0]]);
  assign mem_rdata = mem[mem_addr[7:0]];

  always @(posedge clk or negedge rst_n)
    if (!rst_n) wcnt <= 0;
    else if (mem_req && !mem_ready) wcnt <= wcnt + 1;
    else wcnt <= 0;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // control unit: op 1=ADDI 2=LD 3=ST 4=BR, others no-op
  wire [3:0] op = ir[15:12];
  assign cu_reg_write  = (op == 4'd1) || (op == 4'd2);
  assign cu_flag_write = (op == 4'd1);
  assign cu_mem_read   = (op == 4'd2);
  assign cu_mem_write  = (op == 4'd3);
  assign cu_is_branch  = (op == 4'd4);
  assign alu_result    = {8'h00, ir[7:0]};
  assign store_data    = 16'h1234;
  assign branch_target = {8'h00, ir[7:0]};
  assign branch_taken  = ir[11] & ~br_seen;   // condition true only once
  always @(posedge clk) if (state == 3'd3 && cu_is_branch) br_seen <= 1'b1;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  // scoreboard
  typedef struct {
    bit          is_wb;
    logic        we;
    logic        rf;
    logic        fl;
    logic [15:0] addr;
    logic [15:0] data;
  } ev_t;
  ev_t exp_q[$];
  int  fcyc[$], wcyc[$];

  task automatic push_mem(input logic we, input logic [15:0] a, input logic [15:0] d);
    ev_t e;
    e.is_wb = 1'b0; e.we = we; e.rf = 1'b0; e.fl = 1'b0; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic push_wb(input logic rf, input logic fl, input logic [15:0] m);
    ev_t e;
    e.is_wb = 1'b1; e.we = 1'b0; e.rf = rf; e.fl = fl; e.addr = 16'h0; e.data = m;
    exp_q.push_back(e);
  endtask

  task automatic take_ev(input string name, input ev_t a);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: unexpected event wb=%0d we=%0d addr=%h data=%h", name, a.is_wb, a.we, a.addr, a.data);
    end else begin
      e = exp_q.pop_front();
      chk(name, {a.is_wb, a.we, a.rf, a.fl, a.addr, a.data},
                {e.is_wb, e.we, e.rf, e.fl, e.addr, e.data});
    end
  endtask

  always @(negedge clk) if (rst_n) begin
    ev_t a;
    if (mem_req && mem_ready) begin
      a.is_wb = 1'b0; a.we = mem_we; a.rf = 1'b0; a.fl = 1'b0; a.addr = mem_addr;
      a.data = mem_we ? mem_wdata : mem_rdata;
      if (state == 3'd1) fcyc.push_back(cyc);
      take_ev("mem_access", a);
    end else if (mem_req && exp_q.size() > 0) begin
      chk("stall_addr_we", {mem_we, mem_addr}, {exp_q[0].we, exp_q[0].addr});
    end
    if (rf_we || flag_we) begin
      a.is_wb = 1'b1; a.we = 1'b0; a.rf = rf_we; a.fl = flag_we; a.addr = 16'h0; a.data = mdr;
      wcyc.push_back(cyc);
      take_ev("writeback", a);
    end
  end

  int lat_exp [0:8] = '{4, -1, 4, 4, 4, 3, 4, 4, 3};

  initial begin
    for (int i = 0; i < 256; i++) begin mem[i] = 16'h0000; waits[i] = 0; end
    mem[0] = 16'h1005; mem[1] = 16'h2012; mem[2] = 16'h3020; mem[5] = 16'h4803;
    mem[6] = 16'hFFFF; mem[8'h12] = 16'hBEEF; waits[8'h12] = 2;

    repeat (3) @(negedge clk);
    chk("reset_outputs", {pc, ir, mdr, state, mem_req, mem_we, mem_addr, rf_we, flag_we, halted}, 64'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_without_run", {state, mem_req}, {3'd0, 1'b0});

    push_mem(0, 16'h0000, 16'h1005); push_wb(1, 1, 16'h0000);
    push_mem(0, 16'h0001, 16'h2012); push_mem(0, 16'h0012, 16'hBEEF); push_wb(1, 0, 16'hBEEF);
    push_mem(0, 16'h0002, 16'h3020); push_mem(1, 16'h0020, 16'h1234);
    push_mem(0, 16'h0003, 16'h0000); push_mem(0, 16'h0004, 16'h0000);
    push_mem(0, 16'h0005, 16'h4803);
    push_mem(0, 16'h0003, 16'h0000); push_mem(0, 16'h0004, 16'h0000);
    push_mem(0, 16'h0005, 16'h4803); push_mem(0, 16'h0006, 16'hFFFF);
    run = 1'b1;

    // drop run during the load's memory wait
    for (int i = 0; i < 50 && state != 3'd4; i++) @(negedge clk);
    chk("reach_load_mem", state, 3'd4);
    run = 1'b0;
    for (int i = 0; i < 50 && state != 3'd0; i++) @(negedge clk);
    chk("idle_after_load", state, 3'd0);
    chk("pc_after_load", pc, 16'h0002);
    chk("mdr_after_load", mdr, 16'hBEEF);
    repeat (3) @(negedge clk);
    chk("idle_hold", {state, mem_req}, {3'd0, 1'b0});
    run = 1'b1;

    for (int i = 0; i < 200 && !halted; i++) @(negedge clk);
    chk("halted", {halted, state}, {1'b1, 3'd6});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("halt_no_req", {mem_req, halted}, {1'b0, 1'b1});
    end
    chk("scoreboard_drained", exp_q.size(), 0);

    if (fcyc.size() == 10 && wcyc.size() == 2) begin
      for (int i = 0; i < 9; i++)
        if (lat_exp[i] > 0) chk($sformatf("latency_%0d", i), fcyc[i+1] - fcyc[i], lat_exp[i]);
      chk("addi_wb_cycle4", wcyc[0] - fcyc[0], 3);
      chk("load_wb_cycle7", wcyc[1] - fcyc[1], 6);
    end else begin
      checks++; errors++;
      $display("FAIL event_counts: actual fetch=%0d wb=%0d required fetch=10 wb=2", fcyc.size(), wcyc.size());
    end

    // reset in the middle of a stalled fetch
    waits[0] = 3;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10 && !mem_req; i++) @(negedge clk);
    chk("fetch_before_reset", {state, mem_req, mem_addr}, {3'd1, 1'b1, 16'h0000});
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {pc, ir, mdr, state, mem_req, mem_we, mem_addr, rf_we, flag_we, halted}, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
